// File: rtl/nios_tester_pkg.sv
// rtl/nios_tester_pkg.sv - shared constants for the tester pin debouncer
// Synchroniser depth follows NIOS_TESTER_SYNC3_EN (3 stages when defined, else 2).
package nios_tester_pkg;

  localparam int PIN_COUNT              = 32;
  localparam int CNT_W                  = 8;
  localparam int DEFAULT_TICK_DIV       = 1000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 16;

`ifdef NIOS_TESTER_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [PIN_COUNT-1:0] pins_t;

endpackage

// File: rtl/nios_tester_debounce_bit.sv
// rtl/nios_tester_debounce_bit.sv - one pin: synchroniser, stable level and tick counter
// Synchroniser depth set by NIOS_TESTER_SYNC3_EN through nios_tester_pkg.
module nios_tester_debounce_bit
  import nios_tester_pkg::*;
#(
  parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter logic RESET_BIT      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic tick,
  output logic stable,
  output logic update
);

  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  cnt_t                   cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign update = (sync != stable) && tick && (cnt == CNT_LAST);

  // Any return to the stable level throws away the partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_BIT;
      cnt    <= '0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/nios_tester_pin_debounce.sv
// rtl/nios_tester_pin_debounce.sv - 32-pin synchroniser/debouncer feeding the NIOS PIO in_port
// Synchroniser depth selected by NIOS_TESTER_SYNC3_EN (see nios_tester_pkg).
module nios_tester_pin_debounce
  import nios_tester_pkg::*;
#(
  parameter int    TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int    DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter pins_t RESET_VAL      = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pins_in,
  output logic [31:0] pins_out,
  output logic        changed
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  pins_t            update;
  pins_t            stable;

  assign tick = (div == DIV_LAST);

  // Shared prescaler; with TICK_DIV of 1 the counter sits at 0 and ticks every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < PIN_COUNT; i++) begin : g_bit
    nios_tester_debounce_bit #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .RESET_BIT      (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (pins_in[i]),
      .tick    (tick),
      .stable  (stable[i]),
      .update  (update[i])
    );
  end

  assign pins_out = stable;

  // Registered alongside stable so the pulse lines up with the new pins_out value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |update;
    end
  end

endmodule

// File: tb/tb_nios_tester_pin_debounce.sv
// tb/tb_nios_tester_pin_debounce.sv - self-checking bench for nios_tester_pin_debounce
// Honours NIOS_TESTER_SYNC3_EN for the expected synchroniser delay.
module tb_nios_tester_pin_debounce;

  localparam int          TD = 4;
  localparam int          DT = 3;
  localparam logic [31:0] RV = 32'h0;
`ifdef NIOS_TESTER_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pins_in = RV;
  logic [31:0] pins_out;
  logic        changed;

  nios_tester_pin_debounce #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DT),
    .RESET_VAL      (RV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: the synchronised view is the pin value SYNC_N edges old; a bit is
  // accepted on the DT-th prescaler tick seen while it continuously disagrees.
  logic [31:0] m_stable;
  logic        m_changed;
  int          m_ticks[32];
  logic [31:0] m_q[$];
  int          m_edges;

  task automatic m_reset();
    m_stable  = RV;
    m_changed = 1'b0;
    foreach (m_ticks[i]) m_ticks[i] = 0;
    m_q.delete();
    repeat (SYNC_N) m_q.push_back(RV);
    m_edges = 0;
  endtask

  task automatic m_edge();
    logic [31:0] s;
    logic        tk;
    if (!reset_n) begin
      m_reset();
    end else begin
      s = m_q.pop_front();
      m_q.push_back(pins_in);
      m_edges++;
      tk = (m_edges % TD) == 0;
      m_changed = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (s[i] == m_stable[i]) begin
          m_ticks[i] = 0;
        end else if (tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == DT) begin
            m_stable[i]  = s[i];
            m_ticks[i]   = 0;
            m_changed    = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    vectors++;
    assert (val >= lo && val <= hi) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    check("pins_out", pins_out, m_stable);
    check("changed", {31'b0, changed}, {31'b0, m_changed});
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  // Steps up to max clocks; reports the first clock where all mask bits are high.
  task automatic run_until_rise(input int max, input logic [31:0] mask,
                                output int at, output int pulses, output logic chg_at);
    at = -1;
    pulses = 0;
    chg_at = 1'b0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (changed) pulses++;
      if (at < 0 && (pins_out & mask) == mask) begin
        at = k;
        chg_at = changed;
      end
    end
  endtask

  task automatic async_reset_check();
    reset_n = 1'b0;
    #1;
    m_reset();
    check("async_rst_pins_out", pins_out, RV);
    check("async_rst_changed", {31'b0, changed}, 32'h0);
  endtask

  int   at;
  int   pulses;
  logic chg_at;
  int   hold;

  initial begin
    m_reset();

    // Reset held with all pins high
    pins_in = 32'hFFFF_FFFF;
    async_reset_check();
    settle(3);
    reset_n = 1'b1;
    run_until_rise(20, 32'hFFFF_FFFF, at, pulses, chg_at);
    check_range("reset_release_latency", at, 11, 14);
    check("reset_release_pulses", pulses, 32'd1);
    check("reset_release_chg_at_rise", {31'b0, chg_at}, 32'h1);

    pins_in = 32'h0;
    settle(20);

    // Clean step on bit 0
    pins_in = 32'h1;
    run_until_rise(20, 32'h1, at, pulses, chg_at);
    check_range("clean_step_latency", at, 11 + SYNC_N - 2, 14 + SYNC_N - 2);
    check("clean_step_pulses", pulses, 32'd1);
    check("clean_step_chg_at_rise", {31'b0, chg_at}, 32'h1);
    check("clean_step_value", pins_out, 32'h1);

    pins_in = 32'h0;
    settle(20);

    // Short glitch on bit 5
    pins_in = 32'h20;
    settle(6);
    pins_in = 32'h0;
    run_until_rise(20, 32'h20, at, pulses, chg_at);
    check("glitch_no_rise", at, -1);
    check("glitch_no_pulse", pulses, 32'd0);

    // Bit 5 toggling every 3 clocks
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      if (k % 3 == 0) pins_in = pins_in ^ 32'h20;
      step();
      if (changed) pulses++;
    end
    check("toggle_no_pulse", pulses, 32'd0);
    check("toggle_out_low", pins_out, 32'h0);
    pins_in = 32'h0;
    settle(20);

    // Simultaneous flips
    pins_in = 32'hA5A5_A5A5;
    run_until_rise(20, 32'hA5A5_A5A5, at, pulses, chg_at);
    check_range("simul_latency", at, 11 + SYNC_N - 2, 14 + SYNC_N - 2);
    check("simul_pulses", pulses, 32'd1);
    check("simul_chg_at_rise", {31'b0, chg_at}, 32'h1);
    check("simul_value", pins_out, 32'hA5A5_A5A5);

    pins_in = 32'h0;
    settle(20);

    // Reset in the middle of a count
    pins_in = 32'h1;
    settle(8);
    async_reset_check();
    settle(2);
    reset_n = 1'b1;
    run_until_rise(20, 32'h1, at, pulses, chg_at);
    check_range("midcount_reset_latency", at, 12, 15);
    check("midcount_reset_pulses", pulses, 32'd1);

    // Random segments with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      pins_in = $urandom;
      if ($urandom_range(0, 2) == 0) pins_in = pins_in & 32'h0000_FFFF;
      hold = $urandom_range(1, 24);
      if ($urandom_range(0, 9) == 0) begin
        async_reset_check();
        step();
        reset_n = 1'b1;
      end
      settle(hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_tester_pin_debounce.md
# nios_tester_pin_debounce

Input conditioner directly upstream of the tester's 32-bit NIOS PIO input port. It synchronises 32 asynchronous tester pins into the system clock domain and debounces each bit independently against a shared tick prescaler. It drives the PIO `in_port` with clean, glitch-free levels. It also raises a one-cycle change strobe whenever any debounced bit flips.

## Interface
Parameters:
- `TICK_DIV`, 1000: clocks per debounce tick; legal range ≥1; 1 means a tick every clock.
- `DEBOUNCE_TICKS`, 16: consecutive ticks a new level must persist before it is accepted; legal range 1..255.
- `RESET_VAL`, 32'h0: value of `pins_out` during and after reset.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `pins_in`, in, 32: raw asynchronous tester pins.
- `pins_out`, out, 32: debounced levels; connects to the PIO `in_port`.
- `changed`, out, 1: one-cycle pulse when any `pins_out` bit changes.

## Operation
- **Synchroniser.** Each bit passes through 2 flip-flops; with the Configuration macro it passes through 3. The synchroniser stages reset to `RESET_VAL`.
- **Prescaler.**
  - Counter `div` runs 0..`TICK_DIV`-1 and wraps.
  - `tick` is asserted for one clock when `div` == `TICK_DIV`-1.
  - Reset value of `div` is 0.
- **Per-bit state.** Each bit holds `stable` (reset `RESET_VAL[i]`) and a counter `cnt` (8 bit, reset 0).
  - `sync` == `stable`: `cnt` is set to 0, regardless of `tick`.
  - `sync` != `stable` and no `tick`: `cnt` holds.
  - `sync` != `stable`, `tick`, and `cnt` < `DEBOUNCE_TICKS`-1: `cnt` increments by 1.
  - `sync` != `stable`, `tick`, and `cnt` == `DEBOUNCE_TICKS`-1: `stable` is set to `sync` and `cnt` is set to 0.
- `cnt` never exceeds `DEBOUNCE_TICKS`-1, so no wrap-around is possible.
- **Glitch rejection.** Any return of `sync` to `stable` before acceptance discards the partial count.
- **Outputs.**
  - `pins_out` = `stable` (registered).
  - `changed` = registered OR over all bits of "`stable` updates this cycle". It is asserted in the same cycle that `pins_out` shows the new value.
- **Simultaneous flips.** Several bits flipping in the same cycle produce a single one-cycle `changed` pulse.
- **Reset mid-operation.** Asserting `reset_n` low immediately forces:
  - `pins_out` = `RESET_VAL`;
  - `changed` = 0;
  - all `cnt` = 0 and `div` = 0.

  Partial counts are lost.

## Timing
- Latency from a pin change to the synchroniser output: 2 clocks (3 with the macro).
- Latency from the synchroniser output changing to `pins_out` changing, for a held level: at least (`DEBOUNCE_TICKS`-1)·`TICK_DIV`+1 clocks and at most `DEBOUNCE_TICKS`·`TICK_DIV` clocks. The exact value depends on the prescaler phase.
- With `TICK_DIV`=1 and `DEBOUNCE_TICKS`=1, the latency from synchroniser output to `pins_out` is exactly 1 clock.
- `changed` is never asserted in the first clock after reset deassertion.

## Configuration
- **`NIOS_TESTER_SYNC3_EN` defined:**
  - 3-stage synchroniser per bit.
  - Total minimum latency from pin to `pins_out` increases by 1 clock.
- **Not defined:** 2-stage synchroniser.
- The macro causes no other behavioural difference.

## Structure
- Shared package `nios_tester_pkg` holds:
  - the default constants `TICK_DIV` and `DEBOUNCE_TICKS`;
  - the 8-bit debounce counter width;
  - the pin count (32).
- Sub-module `nios_tester_debounce_bit` contains one bit's synchroniser, `stable` and `cnt`. It is instantiated 32× by a generate loop.
- The top level holds the prescaler and the `changed` reduction/register.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_TICKS`=3, `RESET_VAL`=0, macro undefined, unless stated otherwise.
- **Reset:** hold `reset_n`=0 with `pins_in`=32'hFFFFFFFF → `pins_out`=0, `changed`=0; after release, `pins_out`=32'hFFFFFFFF after 11–14 clocks, with one `changed` pulse.
- **Clean step:** `pins_in[0]` 0→1 and held → `pins_out[0]` rises 11–14 clocks later, coincident with one 1-clock `changed` pulse; all other bits stay 0.
- **Glitch:** `pins_in[5]` high for 6 clocks, then low → `pins_out` stays 0 and `changed` never asserts. Repeat with the bit toggling every 3 clocks for 200 clocks → no change.
- **Simultaneous flips:** `pins_in` 0→32'hA5A5A5A5 in one clock → all 16 set bits update in the same cycle and `changed` pulses exactly once.
- **Reset mid-count:** assert reset 8 clocks after `pins_in`=32'h1 while `pins_out`=0, release after 2 clocks → `pins_out` stays 0 for at least 11 clocks after release, then goes to 32'h1.
- **Macro defined:** repeat the clean-step scenario → `pins_out[0]` rises 12–15 clocks after the pin change.
